// File: rtl/rs_quad_gen.sv
// Quadrature step generator: queued direction commands become one Gray-coded
// 00->10->11->01->00 (or reversed) detent each on the registered rot_a/rot_b pair.
module rs_quad_gen #(
   parameter int PHASE_CYCLES = 4,
   parameter int DEPTH        = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   input  logic                     cmd_dir,
   output logic                     cmd_ready,
   input  logic                     clr,
   output logic                     rot_a,
   output logic                     rot_b,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic [2:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH1  = 3'd1,
      PH2  = 3'd2,
      PH3  = 3'd3,
      PH4  = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            dir_q, dir_n;
   logic            a_n, b_n;

   logic [DEPTH-1:0] fifo_mem;
   logic [AW-1:0]    wptr, rptr;
   logic [LW-1:0]    count;
   logic             full, push, pop;

   // Handshake: a command is taken on a rising edge where cmd_valid is high and
   // either cmd_ready is high or the head is being popped that same edge (a full
   // FIFO then swaps one entry for the new one). clr discards any offer that cycle.
   assign full      = (count == LW'(DEPTH));
   assign pop       = (state == IDLE) && (count != '0) && !clr;
   assign push      = cmd_valid && !clr && (!full || pop);
   assign cmd_ready = !full;
   assign busy      = (state != IDLE) || (count != '0);
   assign level     = count;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
      end else if (clr) begin
         rptr  <= wptr;
         count <= '0;
      end else begin
         if (push) begin
            fifo_mem[wptr] <= cmd_dir;
            wptr           <= wptr + AW'(1);
         end
         if (pop)
            rptr <= rptr + AW'(1);
         if (push && !pop)
            count <= count + LW'(1);
         else if (pop && !push)
            count <= count - LW'(1);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dir_n   = dir_q;
      case (state)
         IDLE: begin
            if (pop) begin
               state_n = PH1;
               cnt_n   = CW'(PHASE_CYCLES - 1);
               dir_n   = fifo_mem[rptr];
            end
         end
         PH1, PH2, PH3, PH4: begin
            if (cnt == '0) begin
               cnt_n = CW'(PHASE_CYCLES - 1);
               case (state)
                  PH1:     state_n = PH2;
                  PH2:     state_n = PH3;
                  PH3:     state_n = PH4;
                  default: begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end
               endcase
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the pins flip on the same edge
   // the state does, straight out of flops.
   always_comb begin
      a_n = 1'b0;
      b_n = 1'b0;
      case (state_n)
         PH1: begin
            a_n = !dir_n;
            b_n = dir_n;
         end
         PH2: begin
            a_n = 1'b1;
            b_n = 1'b1;
         end
         PH3: begin
            a_n = dir_n;
            b_n = !dir_n;
         end
         default: begin
            a_n = 1'b0;
            b_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         dir_q <= 1'b0;
         rot_a <= 1'b0;
         rot_b <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dir_q <= dir_n;
         rot_a <= a_n;
         rot_b <= b_n;
      end
   end

endmodule
